core_sequencer: RTL and testbench
=================================

// Module: core_sequencer
// PURPOSE
//   Multi-cycle control FSM for the 9-bit accumulator core. Sequences fetch -> decode -> execute
//   -> (memory wait) -> writeback per instruction: drives IMEM address/read, pulses the decoder's
//   dec_do, gates RF/DMEM write enables from the latched ucode, and resolves JZ/JNZ via the jump LUT.
//   Owns the PC and the start/done program handshake with the testbench/top level.
// PARAMETERS
//   PC_W      10   program counter / IMEM address width
//   START_PC  0    PC loaded on start
//   CNT_W     16   width of the busy-cycle counter
// PORTS
//   clk              in   1      core clock, all state changes on posedge
//   reset            in   1      synchronous, active-high reset
//   start            in   1      level; sampled in IDLE/HALT to launch a program
//   done             out  1      high while in HALT
//   busy             out  1      high in FETCH..WB
//   imem_addr        out  PC_W   current PC
//   imem_rd          out  1      high in FETCH only
//   dec_do           out  1      decoder latch strobe, high in DECODE only
//   uc_ex_jump       in   1      ucode.ExJump
//   uc_jump_on_zero  in   1      ucode.JumpOnZero
//   uc_signal_done   in   1      ucode.SignalDone
//   uc_in_use_dmem   in   1      ucode.InUseDMEM (load)
//   uc_out_rf_write  in   1      ucode.OutRFWrite
//   uc_out_dm_write  in   1      ucode.OutDMWrite (store)
//   uc_imm           in   5      ucode.Immediate[4:0], jump LUT index
//   acc_is_zero      in   1      accumulator == 0, valid in EXEC
//   jmp_idx          out  5      LUT index, registered in EXEC
//   jmp_target       in   PC_W   combinational LUT output for jmp_idx
//   dm_re            out  1      DMEM read request, held in MEMWAIT for loads
//   dm_we            out  1      DMEM write request, held in MEMWAIT for stores
//   dm_ready         in   1      DMEM completes request in the cycle it is high
//   rf_we            out  1      register-file write enable, one cycle in WB
//   cycle_count      out  CNT_W  cycles spent busy since last start, saturating
// BEHAVIOUR
//   Reset: state=IDLE, pc=START_PC, jmp_idx=0, taken=0, cycle_count=0; every output 0. Reset
//     has priority over all events, including mid-instruction; no partial writes are issued after it.
//   States: IDLE, FETCH, DECODE, EXEC, MEMWAIT, WB, HALT.
//   IDLE: start=1 -> pc<=START_PC, cycle_count<=0, FETCH.
//   FETCH (1 cycle): imem_rd=1, imem_addr=pc -> DECODE (IMEM data valid next cycle).
//   DECODE (1 cycle): dec_do=1 -> EXEC; ucode registers valid from EXEC onward.
//   EXEC (1 cycle): priority order:
//     uc_signal_done -> HALT (no writes, pc unchanged);
//     uc_in_use_dmem | uc_out_dm_write -> MEMWAIT;
//     else -> WB. Also registers jmp_idx<=uc_imm and
//     taken <= uc_ex_jump & (acc_is_zero == uc_jump_on_zero).
//   MEMWAIT: dm_re=uc_in_use_dmem, dm_we=uc_out_dm_write, both held until dm_ready; on
//     dm_ready -> WB. Stores write DMEM here only; never assert rf_we for a store.
//   WB (1 cycle): rf_we = uc_out_rf_write & ~uc_out_dm_write; pc <= taken ? jmp_target :
//     pc+1 (mod 2^PC_W, wraps to 0 from all-ones); -> FETCH.
//   HALT: done=1, busy=0; start=1 -> relaunch exactly as from IDLE (done drops next cycle).
//   Latency: 4 cycles per non-memory instruction, 5+N for memory ops (N = dm_ready wait cycles).
//   cycle_count increments every cycle busy=1, saturates at all-ones, cleared on launch.
//   Jumps: target taken in WB, so the fall-through instruction is never fetched; no flush needed.
//   start held high during FETCH..WB is ignored.
// TESTING
//   Reset, then start=1 one cycle -> imem_rd=1 on cycle 1 at addr 0, dec_do=1 on cycle 2, rf_we on cycle 4 for ADD.
//   JZ with uc_jump_on_zero=1, acc_is_zero=1, jmp_target=0x2A -> next imem_addr=0x2A; acc_is_zero=0 -> pc+1.
//   Load with dm_ready low 3 cycles -> dm_re held 4 cycles, rf_we once after; store -> dm_we only, rf_we=0.
//   pc=0x3FF non-jump instruction -> next fetch at 0x000; DONE instr -> done=1, cycle_count frozen, restart clears.
//   reset asserted during MEMWAIT -> next cycle IDLE, dm_re/dm_we/rf_we=0, pc=START_PC, no write observed.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the 9-bit accumulator core.
// Walks each instruction through fetch, decode, execute, an optional memory
// wait and writeback. It owns the PC, resolves conditional jumps through the
// external jump LUT, and runs the start/done program handshake.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | after reset, waiting for start
// FETCH   | imem_rd high, IMEM addressed with pc
// DECODE  | dec_do strobe; decoder latches ucode for the rest of the instr
// EXEC    | branch condition and LUT index registered, next path chosen
// MEMWAIT | DMEM read/write held until dm_ready
// WB      | optional RF write, pc advances or jumps
// HALT    | program finished; done high, start relaunches
module core_sequencer #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] START_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  output logic             busy,
  output logic [PC_W-1:0]  imem_addr,
  output logic             imem_rd,
  output logic             dec_do,
  input  logic             uc_ex_jump,
  input  logic             uc_jump_on_zero,
  input  logic             uc_signal_done,
  input  logic             uc_in_use_dmem,
  input  logic             uc_out_rf_write,
  input  logic             uc_out_dm_write,
  input  logic [4:0]       uc_imm,
  input  logic             acc_is_zero,
  output logic [4:0]       jmp_idx,
  input  logic [PC_W-1:0]  jmp_target,
  output logic             dm_re,
  output logic             dm_we,
  input  logic             dm_ready,
  output logic             rf_we,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEMWAIT = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [4:0]       jmp_idx_q, jmp_idx_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_w;

  // State register; reset wins over every in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= START_PC;
      jmp_idx_q <= '0;
      taken_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      jmp_idx_q <= jmp_idx_d;
      taken_q   <= taken_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state, PC/branch bookkeeping and per-state strobes.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    jmp_idx_d = jmp_idx_q;
    taken_d   = taken_q;
    cnt_d     = cnt_q;
    imem_rd   = 1'b0;
    dec_do    = 1'b0;
    dm_re     = 1'b0;
    dm_we     = 1'b0;
    rf_we     = 1'b0;

    busy_w = (state_q == S_FETCH) || (state_q == S_DECODE) ||
             (state_q == S_EXEC)  || (state_q == S_MEMWAIT) ||
             (state_q == S_WB);

    // Busy-cycle counter sticks at all-ones rather than wrapping.
    if (busy_w && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = START_PC;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        imem_rd = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        dec_do  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        jmp_idx_d = uc_imm;
        taken_d   = uc_ex_jump & (acc_is_zero == uc_jump_on_zero);
        if (uc_signal_done) begin
          state_d = S_HALT;
        end else if (uc_in_use_dmem || uc_out_dm_write) begin
          state_d = S_MEMWAIT;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEMWAIT: begin
        dm_re = uc_in_use_dmem;
        dm_we = uc_out_dm_write;
        if (dm_ready) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        // A store already committed in MEMWAIT; it must not also hit the RF.
        rf_we   = uc_out_rf_write & ~uc_out_dm_write;
        // Jump resolves here, so the fall-through word is never fetched.
        pc_d    = taken_q ? jmp_target : pc_q + 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status and address outputs come straight from the registered state.
  always_comb begin
    busy        = busy_w;
    done        = (state_q == S_HALT);
    imem_addr   = pc_q;
    jmp_idx     = jmp_idx_q;
    cycle_count = cnt_q;
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed instruction stream with a scoreboard of
// expected output events checked by an independent monitor.
module tb_core_sequencer;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  localparam int EV_FETCH = 0;
  localparam int EV_DEC   = 1;
  localparam int EV_MEM   = 2;
  localparam int EV_RFW   = 3;
  localparam int EV_DONE  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             done, busy, imem_rd, dec_do, dm_re, dm_we, rf_we;
  logic [PC_W-1:0]  imem_addr;
  logic             uc_ex_jump, uc_jump_on_zero, uc_signal_done;
  logic             uc_in_use_dmem, uc_out_rf_write, uc_out_dm_write;
  logic [4:0]       uc_imm;
  logic             acc_is_zero;
  logic [4:0]       jmp_idx;
  logic [PC_W-1:0]  jmp_target;
  logic             dm_ready;
  logic [CNT_W-1:0] cycle_count;

  logic [PC_W-1:0]  lut [32];

  typedef struct {
    int          kind;
    logic [15:0] val;
  } evt_t;

  evt_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic done_prev = 1'b0;

  logic [PC_W-1:0]  m_pc;
  logic [CNT_W-1:0] m_cnt;

  core_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .dec_do(dec_do),
    .uc_ex_jump(uc_ex_jump), .uc_jump_on_zero(uc_jump_on_zero),
    .uc_signal_done(uc_signal_done), .uc_in_use_dmem(uc_in_use_dmem),
    .uc_out_rf_write(uc_out_rf_write), .uc_out_dm_write(uc_out_dm_write),
    .uc_imm(uc_imm), .acc_is_zero(acc_is_zero), .jmp_idx(jmp_idx),
    .jmp_target(jmp_target), .dm_re(dm_re), .dm_we(dm_we),
    .dm_ready(dm_ready), .rf_we(rf_we), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // External jump LUT model
  assign jmp_target = lut[jmp_idx];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [15:0] v);
    evt_t e;
    e.kind = k;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic expect_evt(input int k, input logic [15:0] v);
    evt_t e;
    n_cmp++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d val 0x%0h expected none", k, v);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.val !== v) begin
        n_fail++;
        $display("FAIL event: got kind %0d val 0x%0h expected kind %0d val 0x%0h",
                 k, v, e.kind, e.val);
      end
    end
  endtask

  // Monitor: every observable output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (imem_rd === 1'b1)               expect_evt(EV_FETCH, {6'b0, imem_addr});
    if (dec_do === 1'b1)                expect_evt(EV_DEC, 16'h0);
    if ((dm_re | dm_we) === 1'b1)       expect_evt(EV_MEM, {14'b0, dm_re, dm_we});
    if (rf_we === 1'b1)                 expect_evt(EV_RFW, 16'h0);
    if (done === 1'b1 && !done_prev)    expect_evt(EV_DONE, cycle_count);
    done_prev = (done === 1'b1);
  end

  task automatic set_uc(input logic ej, input logic joz, input logic sd, input logic ld,
                        input logic rfw, input logic dmw, input logic [4:0] imm,
                        input logic az);
    uc_ex_jump      = ej;
    uc_jump_on_zero = joz;
    uc_signal_done  = sd;
    uc_in_use_dmem  = ld;
    uc_out_rf_write = rfw;
    uc_out_dm_write = dmw;
    uc_imm          = imm;
    acc_is_zero     = az;
  endtask

  task automatic wait_fetch();
    int t = 0;
    while (imem_rd !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (imem_rd !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL fetch_timeout: got imem_rd=%b expected 1", imem_rd);
    end
  endtask

  // Launch a program; returns at the negedge of the first FETCH cycle.
  task automatic launch(input logic hold);
    m_pc  = '0;
    m_cnt = '0;
    push(EV_FETCH, 16'h0);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    chk("launch_cnt_clear", cycle_count, 0);
    chk("launch_done_low", done, 0);
    chk("launch_busy", busy, 1);
  endtask

  // One non-DONE instruction; returns at the negedge of its WB cycle.
  task automatic run_instr(input logic ej, input logic joz, input logic ld,
                           input logic rfw, input logic dmw, input logic [4:0] imm,
                           input logic az, input int nwait);
    logic mem, taken;
    wait_fetch();
    set_uc(ej, joz, 1'b0, ld, rfw, dmw, imm, az);
    mem   = ld | dmw;
    taken = ej & (az == joz);
    push(EV_DEC, 16'h0);
    if (mem) begin
      for (int i = 0; i <= nwait; i++) push(EV_MEM, {14'b0, ld, dmw});
    end
    if (rfw && !dmw) push(EV_RFW, 16'h0);
    m_pc = taken ? lut[imm] : m_pc + 1'b1;
    push(EV_FETCH, {6'b0, m_pc});
    m_cnt = m_cnt + (mem ? 16'(5 + nwait) : 16'd4);
    if (mem) begin
      dm_ready = 1'b0;
      repeat (3 + nwait) @(negedge clk);
      dm_ready = 1'b1;
      @(negedge clk);
      dm_ready = 1'b0;
    end else begin
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic run_done();
    logic [CNT_W-1:0] frozen;
    wait_fetch();
    set_uc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    push(EV_DEC, 16'h0);
    m_cnt = m_cnt + 16'd3;
    push(EV_DONE, m_cnt);
    repeat (4) @(negedge clk);
    chk("halt_done", done, 1);
    chk("halt_busy", busy, 0);
    frozen = m_cnt;
    repeat (3) @(negedge clk);
    chk("halt_cnt_frozen", cycle_count, frozen);
    chk("halt_pc_held", imem_addr, m_pc);
    set_uc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected program completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) lut[i] = 10'((i * 37) & 10'h3FF);
    lut[3] = 10'h02A;
    lut[7] = 10'h3FF;
    reset    = 1'b1;
    start    = 1'b0;
    dm_ready = 1'b0;
    m_pc     = '0;
    m_cnt    = '0;
    set_uc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_strobes", {imem_rd, dec_do, dm_re, dm_we, rf_we}, 0);
    chk("rst_jmp_idx", jmp_idx, 0);
    chk("rst_cycle_count", cycle_count, 0);

    // Program 1: ALU, jumps, PC wrap, loads/stores, DONE
    launch(1'b0);
    //        ej   joz  ld   rfw  dmw  imm    az   nwait
    run_instr(1'b0,1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,0);  // ADD, pc 0 -> 1
    run_instr(1'b1,1'b1,1'b0,1'b0,1'b0,5'd3, 1'b1,0);  // JZ taken -> 0x2A
    run_instr(1'b1,1'b1,1'b0,1'b0,1'b0,5'd3, 1'b0,0);  // JZ not taken -> 0x2B
    run_instr(1'b1,1'b0,1'b0,1'b0,1'b0,5'd7, 1'b0,0);  // JNZ taken -> 0x3FF
    run_instr(1'b0,1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,0);  // ADD at 0x3FF -> wrap 0
    run_instr(1'b0,1'b0,1'b1,1'b1,1'b0,5'd0, 1'b0,3);  // load, 3 wait cycles
    run_instr(1'b0,1'b0,1'b0,1'b1,1'b1,5'd0, 1'b0,0);  // store with rfw set: no rf_we
    run_instr(1'b0,1'b0,1'b0,1'b0,1'b1,5'd0, 1'b0,2);  // store, 2 wait cycles
    run_done();
    chk("prog1_cycle_count", cycle_count, 16'd43);

    // Program 2: relaunch from HALT, start held high while busy
    launch(1'b1);
    run_instr(1'b0,1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,0);
    run_instr(1'b0,1'b0,1'b1,1'b1,1'b0,5'd0, 1'b0,1);
    start = 1'b0;
    run_done();
    chk("prog2_cycle_count", cycle_count, 16'd13);

    // Program 3: reset in the middle of a load
    launch(1'b0);
    run_instr(1'b0,1'b0,1'b0,1'b1,1'b0,5'd0, 1'b0,0);  // pc -> 1
    wait_fetch();
    set_uc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0);
    push(EV_DEC, 16'h0);
    push(EV_MEM, 16'h2);
    dm_ready = 1'b0;
    repeat (3) @(negedge clk);   // first MEMWAIT cycle
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmw_busy", busy, 0);
    chk("rstmw_done", done, 0);
    chk("rstmw_dm", {dm_re, dm_we, rf_we}, 0);
    chk("rstmw_pc", imem_addr, 0);
    chk("rstmw_queue_drained", q.size(), 0);
    q.delete();
    dm_ready = 1'b1;
    repeat (4) @(negedge clk);
    dm_ready = 1'b0;
    chk("rstmw_idle_busy", busy, 0);

    // Program 4: healthy after mid-instruction reset
    launch(1'b0);
    run_done();
    chk("prog4_cycle_count", cycle_count, 16'd3);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
